// File: rtl/dpi_stream_feeder.sv
// Sequencer feeding the per-category regex matcher bank: load_state, spaced chars, delayed eop.
// Optional DPI_FEEDER_STATS_EN adds wrapping pkt_cnt/byte_cnt outputs.
module dpi_stream_feeder #(
  parameter int NUM_CAT   = 16,
  parameter int LOAD_GAP  = 2,
  parameter int EOP_DELAY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         pkt_data,
  input  logic               pkt_vld,
  input  logic               pkt_sop,
  input  logic               pkt_eop,
  input  logic [5:0]         pkt_sid,
  output logic               pkt_ready,
  input  logic               cfg_we,
  input  logic [5:0]         cfg_addr,
  input  logic [NUM_CAT-1:0] cfg_mask,
  input  logic               clear_seen,
  output logic               load_state,
  output logic               new_stream_id,
  output logic [5:0]         stream_id,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic               eop,
  output logic [NUM_CAT-1:0] enable,
  output logic               busy,
  output logic [15:0]        drop_cnt,
  output logic [2:0]         fsm_state
`ifdef DPI_FEEDER_STATS_EN
  ,
  output logic [31:0]        pkt_cnt,
  output logic [31:0]        byte_cnt
`endif
);

  // Handshake: a beat transfers on any cycle with pkt_vld && pkt_ready;
  // pkt_ready depends only on FSM state, never on pkt_vld.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_GAP    = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_EOP    = 3'd5
  } state_t;

  localparam int CNT_MAX = (LOAD_GAP > EOP_DELAY) ? LOAD_GAP : EOP_DELAY;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [5:0]           sid_q;
  logic [7:0]           char_q;
  logic                 char_vld_q;
  logic                 last_q;
  logic [NUM_CAT-1:0]   enable_q;
  logic [63:0]          seen;
  logic [NUM_CAT-1:0]   mask_tbl [64];
  logic                 accept;

  assign accept    = pkt_vld && pkt_ready;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pkt_vld && pkt_sop) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = (LOAD_GAP == 0) ? S_STREAM : S_GAP;
      S_GAP:    if (cnt == '0) state_nxt = S_STREAM;
      S_STREAM: if (char_vld_q && last_q) state_nxt = (EOP_DELAY == 0) ? S_EOP : S_DRAIN;
      S_DRAIN:  if (cnt == '0) state_nxt = S_EOP;
      S_EOP:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // LOAD presents the live table entry; it is frozen into enable_q for the rest of the packet.
  always_comb begin
    pkt_ready     = 1'b0;
    load_state    = 1'b0;
    new_stream_id = 1'b0;
    stream_id     = '0;
    char_in       = '0;
    char_in_vld   = 1'b0;
    eop           = 1'b0;
    enable        = '0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE:   pkt_ready = !rst;
      S_LOAD: begin
        load_state    = 1'b1;
        new_stream_id = !seen[sid_q];
        stream_id     = sid_q;
        enable        = mask_tbl[sid_q];
      end
      S_GAP: begin
        stream_id = sid_q;
        enable    = enable_q;
      end
      S_STREAM: begin
        pkt_ready   = !last_q;
        stream_id   = sid_q;
        enable      = enable_q;
        char_in     = char_q;
        char_in_vld = char_vld_q;
      end
      S_DRAIN: begin
        stream_id = sid_q;
        enable    = enable_q;
        char_in   = char_q;
      end
      S_EOP: begin
        eop       = 1'b1;
        stream_id = sid_q;
        enable    = enable_q;
        char_in   = char_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sid_q      <= '0;
      char_q     <= '0;
      char_vld_q <= 1'b0;
      last_q     <= 1'b0;
      enable_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (pkt_vld && pkt_sop) begin
          sid_q      <= pkt_sid;
          char_q     <= pkt_data;
          last_q     <= pkt_eop;
          char_vld_q <= 1'b1;
        end
        S_LOAD: begin
          enable_q <= mask_tbl[sid_q];
          cnt      <= CW'(LOAD_GAP - 1);
        end
        S_GAP: if (cnt != '0) cnt <= cnt - CW'(1);
        S_STREAM: begin
          char_vld_q <= accept;
          if (accept) begin
            char_q <= pkt_data;
            last_q <= pkt_eop;
          end
          if (char_vld_q && last_q) cnt <= CW'(EOP_DELAY - 1);
        end
        S_DRAIN: if (cnt != '0) cnt <= cnt - CW'(1);
        S_EOP: begin
          char_q   <= '0;
          last_q   <= 1'b0;
          enable_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // A clear coinciding with the EOP set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             seen <= '0;
    else if (clear_seen) seen <= '0;
    else if (state == S_EOP) seen[sid_q] <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mask_tbl[i] <= '0;
    end else if (cfg_we) begin
      mask_tbl[cfg_addr] <= cfg_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else if (state == S_IDLE && pkt_vld && !pkt_sop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

`ifdef DPI_FEEDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      if (eop)         pkt_cnt  <= pkt_cnt + 32'd1;
      if (char_in_vld) byte_cnt <= byte_cnt + 32'd1;
    end
  end
`endif

endmodule
